decrypt_round_ctrl: RTL
=======================

# decrypt_round_ctrl

Sequencer for the two-round chaos image decryption datapath. On `start` it runs the rounds in reverse key order. Each round runs key expansion, then an inverse-substitution raster sweep over every pixel, then an inverse-permutation raster sweep. It sits between the host/top level and the key-expansion, inverse-substitution and inverse-permutation engines, and drives them over a one-shot request and a per-pixel valid/ready handshake.

## Interface
Parameters:
- `IMG_W`, 256, image width in pixels (≥2).
- `IMG_H`, 256, image height in pixels (≥2).
- `ROUNDS`, 2, number of decryption rounds (≥1).

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a decryption; sampled only in IDLE.
- `busy`  out  1  high from the cycle after accepted `start` through the last PERM handshake.
- `done`  out  1  one-cycle pulse when all rounds complete.
- `round_idx`  out  clog2(ROUNDS+1)  current round, 1..ROUNDS; 0 in IDLE.
- `key_sel`  out  clog2(ROUNDS+1)  round-key index = ROUNDS+1−round_idx; 0 in IDLE.
- `ke_start`  out  1  one-cycle key-expansion request.
- `ke_done`  in  1  key expansion finished; honoured only in KE_WAIT.
- `op_valid`  out  1  pixel operation request.
- `op_ready`  in  1  engine accepts the pixel operation.
- `op_mode`  out  1  0 = inverse substitution, 1 = inverse permutation.
- `op_row`  out  clog2(IMG_H)  pixel row.
- `op_col`  out  clog2(IMG_W)  pixel column.
- `op_last`  out  1  high with the final pixel (IMG_H−1, IMG_W−1) of a sweep.

## Operation
- States: IDLE, KE_REQ, KE_WAIT, SUB, PERM, DONE.
- IDLE: `start`=1 sets round=1 and moves to KE_REQ. Otherwise stay.
- KE_REQ: `ke_start`=1 for exactly this cycle. Unconditionally moves to KE_WAIT.
- KE_WAIT: wait for `ke_done`. On `ke_done`, clear row/col and move to SUB.
- SUB: `op_valid`=1, `op_mode`=0. A handshake is `op_valid & op_ready`. On each handshake the column increments. When the column is IMG_W−1 it wraps to 0 and the row increments. On the handshake with `op_last`, clear row/col and move to PERM.
- PERM: same sweep with `op_mode`=1. On the last handshake:
  - if round < ROUNDS: round increments, go to KE_REQ;
  - otherwise go to DONE.
- DONE: `done`=1 for one cycle and `busy`=0. Moves to IDLE.
- Pixel order is row-major, (0,0) first, in both sweeps.
- While `op_valid` is high and `op_ready` is low, `op_row`, `op_col`, `op_mode` and `op_last` hold stable. `op_valid` never drops without a handshake.
- `start` is ignored in every state except IDLE, including DONE.
- `ke_done` is ignored outside KE_WAIT, including when it is asserted in the same cycle as `ke_start`.
- Row and column counters never exceed IMG_H−1 and IMG_W−1. There is no wrap past the last pixel.

## Timing
- All outputs are registered. Reset values:
  - `busy`, `done`, `ke_start`, `op_valid`, `op_mode`, `op_last` = 0;
  - `op_row`, `op_col`, `round_idx`, `key_sel` = 0;
  - state = IDLE.
- `rst` in any state returns to IDLE on the next edge and drops all outputs to reset values. A sweep is abandoned with no further `op_valid`.
- Accepted `start` at edge 0 gives `busy`=1 and `ke_start`=1 in cycle 1.
- `ke_done` sampled in KE_WAIT gives `op_valid`=1 in the next cycle.
- With `op_ready` tied to 1, a sweep takes IMG_W·IMG_H consecutive cycles.
- With `ke_done` returned 1 cycle after `ke_start` and `op_ready`=1, `done` rises ROUNDS·(2+2·IMG_W·IMG_H)+1 cycles after the `start` edge.
- Back-to-back run: `start` in the cycle after DONE (state IDLE) is accepted.

## Test plan
- IMG_W=IMG_H=4, ROUNDS=2; `ke_done` 1 cycle after `ke_start`; `op_ready`=1. Required:
  - `done` at cycle 69;
  - exactly 64 handshakes (16 SUB, 16 PERM per round);
  - `key_sel` = 2 in round 1 and 1 in round 2.
- Backpressure: `op_ready` random at 30%. Required:
  - `op_row`/`op_col`/`op_mode` stable during stalls;
  - row-major sequence (0,0)…(3,3) with no skips or repeats;
  - `op_last` only on (3,3).
- `ke_done` delayed 10 cycles, plus spurious `ke_done` pulses during SUB and during IDLE. Required: no `op_valid` until the KE_WAIT `ke_done`; spurious pulses have no effect.
- `start` held high throughout a run. Required:
  - a single `done`;
  - second run's `ke_start` exactly 2 cycles after `done` (IDLE accepts, then KE_REQ).
- `rst` asserted mid-SUB of round 2 at pixel (1,2). Required:
  - next cycle all outputs are 0 and state is IDLE;
  - a later `start` begins again at round 1, `key_sel`=2, pixel (0,0).
- ROUNDS=1, IMG_W=2, IMG_H=3. Required:
  - `op_col` wraps 1→0 with `op_row` incrementing;
  - `done` at cycle 1·(2+12)+1=15.

Source files
------------

// File: rtl/decrypt_round_ctrl.sv
// decrypt_round_ctrl: sequences the decryption rounds in reverse key order.
// Each round requests key expansion, then sweeps every pixel through the
// inverse-substitution engine, then every pixel through the inverse-permutation engine.
module decrypt_round_ctrl #(
  parameter int IMG_W  = 256,
  parameter int IMG_H  = 256,
  parameter int ROUNDS = 2,
  localparam int RND_W = $clog2(ROUNDS + 1),
  localparam int ROW_W = $clog2(IMG_H),
  localparam int COL_W = $clog2(IMG_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [RND_W-1:0] round_idx,
  output logic [RND_W-1:0] key_sel,
  output logic             ke_start,
  input  logic             ke_done,
  output logic             op_valid,
  input  logic             op_ready,
  output logic             op_mode,
  output logic [ROW_W-1:0] op_row,
  output logic [COL_W-1:0] op_col,
  output logic             op_last
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_KE_REQ  = 3'd1;
  localparam logic [2:0] S_KE_WAIT = 3'd2;
  localparam logic [2:0] S_SUB     = 3'd3;
  localparam logic [2:0] S_PERM    = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(IMG_W - 1);
  localparam logic [RND_W-1:0] RND_MAX = RND_W'(ROUNDS);

  logic [2:0]       state_q, state_d;
  logic [RND_W-1:0] round_q, round_d;
  logic [RND_W-1:0] key_sel_q, key_sel_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ke_start_q, ke_start_d;
  logic             op_valid_q, op_valid_d;
  logic             op_mode_q, op_mode_d;
  logic             op_last_q, op_last_d;

  logic             hs;
  logic             at_last;

  assign hs      = op_valid_q & op_ready;
  assign at_last = (row_q == ROW_MAX) && (col_q == COL_MAX);

  // Next state, round and pixel counters; outputs are decoded from the next
  // state so that every output port comes straight from a flop.
  always_comb begin
    state_d = state_q;
    round_d = round_q;
    row_d   = row_q;
    col_d   = col_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          round_d = RND_W'(1);
          state_d = S_KE_REQ;
        end
      end
      S_KE_REQ: begin
        state_d = S_KE_WAIT;
      end
      S_KE_WAIT: begin
        if (ke_done) begin
          row_d   = '0;
          col_d   = '0;
          state_d = S_SUB;
        end
      end
      S_SUB, S_PERM: begin
        if (hs) begin
          if (at_last) begin
            row_d = '0;
            col_d = '0;
            if (state_q == S_SUB) begin
              state_d = S_PERM;
            end else if (round_q < RND_MAX) begin
              round_d = round_q + RND_W'(1);
              state_d = S_KE_REQ;
            end else begin
              state_d = S_DONE;
            end
          end else if (col_q == COL_MAX) begin
            col_d = '0;
            row_d = row_q + ROW_W'(1);
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end
      end
      S_DONE: begin
        round_d = '0;
        state_d = S_IDLE;
      end
      default: begin
        round_d = '0;
        row_d   = '0;
        col_d   = '0;
        state_d = S_IDLE;
      end
    endcase

    busy_d     = (state_d == S_KE_REQ) || (state_d == S_KE_WAIT) ||
                 (state_d == S_SUB)    || (state_d == S_PERM);
    done_d     = (state_d == S_DONE);
    ke_start_d = (state_d == S_KE_REQ);
    op_valid_d = (state_d == S_SUB) || (state_d == S_PERM);
    op_mode_d  = (state_d == S_PERM);
    op_last_d  = op_valid_d && (row_d == ROW_MAX) && (col_d == COL_MAX);
    key_sel_d  = (round_d == '0) ? '0 : RND_W'(RND_MAX - round_d + RND_W'(1));
  end

  // State and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      round_q    <= '0;
      key_sel_q  <= '0;
      row_q      <= '0;
      col_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ke_start_q <= 1'b0;
      op_valid_q <= 1'b0;
      op_mode_q  <= 1'b0;
      op_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      round_q    <= round_d;
      key_sel_q  <= key_sel_d;
      row_q      <= row_d;
      col_q      <= col_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ke_start_q <= ke_start_d;
      op_valid_q <= op_valid_d;
      op_mode_q  <= op_mode_d;
      op_last_q  <= op_last_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign round_idx = round_q;
  assign key_sel   = key_sel_q;
  assign ke_start  = ke_start_q;
  assign op_valid  = op_valid_q;
  assign op_mode   = op_mode_q;
  assign op_row    = row_q;
  assign op_col    = col_q;
  assign op_last   = op_last_q;

endmodule
